pipereg_elastic: RTL
====================

Name: pipereg_elastic

Overview:
- Next-generation inter-stage pipeline register: a parametrised control bundle plus a data payload, with a valid/ready handshake.
- A 2-entry skid buffer registers back-pressure, so stalls need no combinational ready path through the stage.
- Synchronous flush converts both entries to bubbles; saturating stall and bubble counters support performance analysis.
- Instantiated between any two pipeline stages (F/D, D/E, E/M, M/W) in place of fixed-field enable/clear registers.

Parameters:
- CTRL_WIDTH, 24, width of the control bundle. Zeroed on bubbles so it acts as a NOP.
- PAYLOAD_WIDTH, 175, width of the data payload.
- CLEAR_PAYLOAD, 1, 1 = payload zeroed on reset and flush; 0 = payload keeps stale value (saves power).
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream holds a valid entry
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_ctrl  in  CTRL_WIDTH  upstream control bundle
- in_payload  in  PAYLOAD_WIDTH  upstream data
- flush  in  1  synchronous clear of both entries (branch mispredict)
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_WIDTH  main entry control; 0 whenever out_valid=0
- out_payload  out  PAYLOAD_WIDTH  main entry data
- occupancy  out  2  entries held, 0..2
- cnt_clr  in  1  synchronous clear of both counters
- stall_cnt  out  CNT_WIDTH  cycles with out_valid && !out_ready, saturating
- bubble_cnt  out  CNT_WIDTH  cycles with !out_valid && out_ready, saturating

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are clk and rst, as elsewhere in the codebase.
- Storage: main entry (drives outputs) and skid entry. Each entry holds valid, ctrl and payload.
- Invariant: skid valid implies main valid; main is always the older entry.
- Events: acc = in_valid && in_ready; fire = out_valid && out_ready.
- Reset (rst=1): both valids 0, all ctrl 0. Payloads 0 if CLEAR_PAYLOAD=1, else unchanged. Counters 0, in_ready=1, occupancy=0.
- Priority order: rst > flush > normal operation. cnt_clr is independent of flush.
- State EMPTY (occ 0):
  - acc -> input loads main, go ONE.
  - no acc -> stay EMPTY.
- State ONE (occ 1):
  - fire && acc -> main <= input, stay ONE.
  - fire only -> main valid 0, ctrl 0, go EMPTY.
  - acc only -> input loads skid, go FULL.
  - neither -> hold.
- State FULL (occ 2): in_ready=0, so acc is impossible.
  - fire -> main <= skid, skid cleared, go ONE.
  - no fire -> hold.
- Latency and throughput: 1 cycle from accept in EMPTY to out_valid. Sustained throughput is 1 entry per cycle in ONE with out_ready held at 1.
- Flush: next cycle both entries are invalid with ctrl 0, and payloads are cleared per CLEAR_PAYLOAD.
  - An input handshaked in the same cycle as flush is dropped.
  - A fire in the flush cycle is still consumed by downstream; flush does not retract it.
  - in_ready=1 on the cycle after a flush.
- Ctrl rule: an invalid entry always stores ctrl=0, so out_ctrl=0 whenever out_valid=0.
- Counters:
  - Each counter increments by 1 in its qualifying cycle and saturates at all-ones.
  - cnt_clr or rst zeroes both; cnt_clr takes precedence over an increment in the same cycle.
  - Counting continues during a flush cycle, based on the pre-flush out_valid.
- in_ready and out_valid are driven from flops only; there is no combinational path from in_* or out_ready to outputs.

Test Plan:
- Reset, then in_valid=1, in_ctrl=0x00000A, in_payload=1, out_ready=1 held for 4 cycles with payloads 1,2,3,4 -> out_payload 1,2,3,4 on consecutive cycles starting 1 cycle after first accept; occupancy=1 throughout; stall_cnt=0.
- ONE state holding payload 5, out_ready=0, push payload 6 -> occupancy=2, in_ready=0. Then out_ready=1 -> outputs 5 then 6, in_ready returns to 1, stall_cnt=1.
- FULL state (entries 7,8), assert flush with in_valid=1 payload 9 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. With CLEAR_PAYLOAD=1, out_payload=0. Payload 9 never appears.
- CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Then cnt_clr=1 for 1 cycle -> stall_cnt=0.
- Idle with out_ready=1 for 3 cycles after reset -> bubble_cnt=3, out_ctrl=0. Assert rst while FULL -> all outputs return to reset values next cycle.
- Random valid/ready toggling for 1000 cycles against a scoreboard FIFO model -> no loss, no duplication, in-order delivery, out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipereg_elastic.sv
// Elastic inter-stage pipeline register: main entry plus a skid entry, so in_ready is a flop.
// Also provides flush-to-bubble and saturating stall/bubble counters.
//
// state | meaning
// EMPTY | no entry held, out_valid=0, in_ready=1
// ONE   | main entry valid, skid empty, in_ready=1
// FULL  | main and skid valid, in_ready=0
module pipereg_elastic #(
    parameter int CTRL_WIDTH    = 24,
    parameter int PAYLOAD_WIDTH = 175,
    parameter bit CLEAR_PAYLOAD = 1'b1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_WIDTH-1:0]    in_ctrl,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_WIDTH-1:0]    out_ctrl,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [1:0]               occupancy,
    input  logic                     cnt_clr,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [CTRL_WIDTH-1:0]    main_ctrl_q, main_ctrl_d;
    logic [CTRL_WIDTH-1:0]    skid_ctrl_q, skid_ctrl_d;
    logic [PAYLOAD_WIDTH-1:0] main_pay_q, main_pay_d;
    logic [PAYLOAD_WIDTH-1:0] skid_pay_q, skid_pay_d;
    logic [CNT_WIDTH-1:0]     stall_q, stall_d;
    logic [CNT_WIDTH-1:0]     bubble_q, bubble_d;
    logic                     acc;
    logic                     fire;

    assign acc  = in_valid && in_ready_q;
    assign fire = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        main_pay_d  = main_pay_q;
        skid_pay_d  = skid_pay_q;

        if (flush) begin
            // a fire in this cycle is still taken downstream; an accept is dropped
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_PAYLOAD) begin
                main_pay_d = '0;
                skid_pay_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_ctrl_d = in_ctrl;
                        main_pay_d  = in_payload;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (fire && acc) begin
                        main_ctrl_d = in_ctrl;
                        main_pay_d  = in_payload;
                    end else if (fire) begin
                        main_ctrl_d = '0;
                        state_d     = EMPTY;
                    end else if (acc) begin
                        skid_ctrl_d = in_ctrl;
                        skid_pay_d  = in_payload;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (fire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_pay_d  = skid_pay_q;
                        skid_ctrl_d = '0;
                        if (CLEAR_PAYLOAD) begin
                            skid_pay_d = '0;
                        end
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // counters look at the pre-edge out_valid, so a flush cycle still counts
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (cnt_clr) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_q != '1)) begin
                stall_d = stall_q + CNT_WIDTH'(1);
            end
            if (!out_valid_q && out_ready && (bubble_q != '1)) begin
                bubble_d = bubble_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
            stall_q     <= '0;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_ctrl_q <= main_ctrl_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_q     <= stall_d;
            bubble_q    <= bubble_d;
        end
    end

    // payloads hold their stale value through reset unless clearing is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLEAR_PAYLOAD) begin
                main_pay_q <= '0;
                skid_pay_q <= '0;
            end
        end else begin
            main_pay_q <= main_pay_d;
            skid_pay_q <= skid_pay_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_ctrl    = main_ctrl_q;
    assign out_payload = main_pay_q;
    assign occupancy   = state_q;
    assign stall_cnt   = stall_q;
    assign bubble_cnt  = bubble_q;

endmodule
